// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, read-first instruction memory with a load port, IDLE/RUN/FAULT control.
// Optional macro FETCH_BOUNDS_CHECK_EN: fetching from a PC above the memory range faults instead of wrapping.
module fetch_stage #(
    parameter int          ADDR_BITS = 3,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INST  = 32'h0000_0013
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 prog_we,
    input  logic [ADDR_BITS-1:0] prog_addr,
    input  logic [31:0]          prog_data,
    input  logic                 stall,
    input  logic                 redirect_valid,
    input  logic [31:0]          redirect_pc,
    output logic [31:0]          pc_out,
    output logic [31:0]          inst_out,
    output logic                 inst_valid,
    output logic                 fault
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FAULT} state_t;

    state_t                 r_state;
    logic [31:0]            r_pc;
    logic [31:0]            r_pc_out;
    logic                   r_valid;
    logic                   r_fault;
    logic [31:0]            r_rd_data;
    logic [31:0]            r_mem [0:(1<<ADDR_BITS)-1];

    logic [ADDR_BITS-1:0]   w_idx;
    logic                   w_oob;
    logic                   w_fetch;
    logic                   w_misaligned;

    assign w_idx        = r_pc[ADDR_BITS+1:2];
    assign w_misaligned = |redirect_pc[1:0];

`ifdef FETCH_BOUNDS_CHECK_EN
    assign w_oob = |r_pc[31:ADDR_BITS+2];
`else
    assign w_oob = 1'b0;
`endif

    assign w_fetch = (r_state == S_RUN) && !redirect_valid && !stall && !w_oob;

    // Memory has no reset; the read register only advances on a real fetch so stall holds inst_out.
    always_ff @(posedge clk) begin
        if (prog_we) begin
            r_mem[prog_addr] <= prog_data;
        end
        if (w_fetch) begin
            r_rd_data <= r_mem[w_idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_pc     <= RESET_PC;
            r_pc_out <= RESET_PC;
            r_valid  <= 1'b0;
            r_fault  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_RUN;
                    end
                end
                S_RUN, S_FAULT: begin
                    if (redirect_valid) begin
                        r_pc    <= redirect_pc;
                        r_valid <= 1'b0;
                        r_fault <= w_misaligned;
                        r_state <= w_misaligned ? S_FAULT : S_RUN;
                    end else if (r_state == S_RUN && !stall) begin
                        if (w_oob) begin
                            r_state <= S_FAULT;
                            r_fault <= 1'b1;
                            r_valid <= 1'b0;
                        end else begin
                            r_pc_out <= r_pc;
                            r_valid  <= 1'b1;
                            r_pc     <= r_pc + 32'd4;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign pc_out     = r_pc_out;
    assign inst_out   = r_valid ? r_rd_data : NOP_INST;
    assign inst_valid = r_valid;
    assign fault      = r_fault;

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Parametrised instruction-fetch stage: PC register, synchronous-read instruction memory with a program-load port, and a small control FSM. It supports stall, branch redirect, and fault reporting. It sits between the program loader and the decode stage, and delivers one registered instruction per cycle with a valid flag. Depth and reset PC are configurable.

## Interface
- ADDR_BITS, 3, log2 of memory depth in 32-bit words (depth = 2^ADDR_BITS).
- RESET_PC, 32'h0000_0000, PC loaded at reset; must be 4-byte aligned.
- NOP_INST, 32'h0000_0013, instruction driven whenever inst_valid = 0.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  level; leaves IDLE and begins fetching.
- prog_we  in  1  memory write enable (load port).
- prog_addr  in  ADDR_BITS  word index for load write.
- prog_data  in  32  load write data.
- stall  in  1  hold PC and all outputs.
- redirect_valid  in  1  load redirect_pc into PC (branch/jump/flush).
- redirect_pc  in  32  byte address of redirect target.
- pc_out  out  32  byte address of inst_out.
- inst_out  out  32  fetched instruction.
- inst_valid  out  1  inst_out/pc_out are a real fetch.
- fault  out  1  sticky fault flag; cleared only by redirect or reset.

## Operation
- FSM states: IDLE, RUN, FAULT.
- IDLE: entered on reset. PC = RESET_PC, inst_valid = 0. Goes to RUN on the first edge with start = 1.
- RUN, per edge with stall = 0 and no redirect:
  - pc_out <= PC; inst_out <= mem[PC[ADDR_BITS+1:2]]; inst_valid <= 1; PC <= PC + 4 (32-bit, wraps at 2^32).
- stall = 1 in RUN: PC, pc_out, inst_out, inst_valid all hold.
- Redirect (redirect_valid = 1), in any state except IDLE; takes priority over stall:
  - PC <= redirect_pc; next edge inst_valid <= 0, inst_out <= NOP_INST (one bubble); fault <= 0.
  - If redirect_pc[1:0] != 0: the next state is FAULT instead of RUN, fault <= 1.
- FAULT: inst_valid = 0, inst_out = NOP_INST, PC frozen. Only a redirect or reset exits.
- Load port: prog_we writes mem[prog_addr] on the edge, in any state.
  - Read-during-write to the same word returns the old data (read-first).
  - The memory is not cleared by reset.
- Reset mid-operation: all outputs and the FSM return to reset values asynchronously. Memory contents are kept.

## Timing
- Reset values: pc_out = RESET_PC, inst_out = NOP_INST, inst_valid = 0, fault = 0, state = IDLE.
- Latency: PC value P presented at edge n → inst_out = mem[P] and pc_out = P after edge n.
- First valid instruction appears one edge after the start edge.
- Redirect at edge n: bubble after edge n; target instruction valid after edge n+1.
- Stall and redirect together: redirect wins.
- Throughput: one instruction per cycle when not stalled.

## Configuration
- FETCH_BOUNDS_CHECK_EN defined:
  - A fetch with PC[31:ADDR_BITS+2] != 0 (outside memory) enters FAULT on that edge, with fault = 1 and inst_valid = 0.
- Undefined:
  - The address is taken modulo depth (upper PC bits ignored); out-of-range never faults.
  - Misaligned-redirect faulting is present in both builds.

## Test plan
- Load mem[0..3] = AAAAAAAA, BBBBBBBB, CCCCCCCC, DDDDDDDD; assert start → consecutive cycles show pc_out 0/4/8/C with the matching inst_out and inst_valid = 1.
- Stall for 3 cycles while pc_out = 4 → pc_out = 4 and inst_out = BBBBBBBB held; then resume at pc_out = 8.
- redirect_valid with redirect_pc = 0xC while stall = 1 → one bubble (inst_valid = 0, inst_out = 00000013), then DDDDDDDD at pc_out = 0xC.
- redirect_pc = 0x6 → fault = 1, inst_valid stays 0; then redirect_pc = 0x0 → fault = 0 and AAAAAAAA after the bubble.
- With FETCH_BOUNDS_CHECK_EN and ADDR_BITS = 3, PC reaching 0x20 → fault = 1. Without the macro, PC 0x20 returns mem[0] = AAAAAAAA.
- Assert rst asynchronously mid-run → outputs are immediately at reset values. After restart, mem[1] still reads BBBBBBBB. A write to word 2 while reading word 2 returns the old value, and the new value on the next pass.
